// File: rtl/choice_pkg.sv
// Shared definitions for the K-of-N monitor: check modes, FSM states and
// the popcount result width helper.
package choice_pkg;

   localparam logic [1:0] MODE_EXACT   = 2'b00;
   localparam logic [1:0] MODE_ATMOST  = 2'b01;
   localparam logic [1:0] MODE_ATLEAST = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   // Bits needed to hold a count of 0..n set bits.
   function automatic int pop_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/choice_popcount.sv
// Combinational popcount of an N-bit vector.
module choice_popcount
   import choice_pkg::*;
#(
   parameter int N = 5
) (
   input  logic [N-1:0]          i_x,
   output logic [pop_w(N)-1:0]   o_pop
);

   localparam int PW = pop_w(N);

   always_comb begin
      o_pop = '0;
      for (int i = 0; i < N; i++) begin
         o_pop = o_pop + PW'(i_x[i]);
      end
   end

endmodule

// File: rtl/choice_k_of_n_monitor.sv
// Streaming K-of-N set-bit checker with registered result, sticky fault FSM and
// saturating violation counter. Define CHOICE_CAPTURE_EN to add first-violation capture.
//
//  state    | meaning
//  ST_IDLE  | no beat seen since reset/clr
//  ST_RUN   | passing beats seen, no violation yet
//  ST_FAULT | at least one violation; left only by clr
module choice_k_of_n_monitor
   import choice_pkg::*;
#(
   parameter int N     = 5,
   parameter int K     = 1,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [N-1:0]          x,
   input  logic [1:0]            mode,
   input  logic                  clr,
   output logic                  y_valid,
   output logic                  y,
   output logic [pop_w(N)-1:0]   pop,
   output logic                  fault,
   output logic [CNT_W-1:0]      viol_cnt
`ifdef CHOICE_CAPTURE_EN
   ,
   output logic [N-1:0]          cap_vec,
   output logic                  cap_valid
`endif
);

   localparam int              PW      = pop_w(N);
   localparam logic [PW-1:0]   LP_K    = PW'(K);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [PW-1:0]    w_pop;
   logic             w_pass;
   logic             w_viol;
   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_y_valid;
   logic             r_y;
   logic [PW-1:0]    r_pop;
   logic [CNT_W-1:0] r_viol_cnt;

   choice_popcount #(.N(N)) u_popcount (
      .i_x   (x),
      .o_pop (w_pop)
   );

   // Reserved mode 11 falls through to the exact-K check.
   always_comb begin
      w_pass = (w_pop == LP_K);
      case (mode)
         MODE_ATMOST:  w_pass = (w_pop <= LP_K);
         MODE_ATLEAST: w_pass = (w_pop >= LP_K);
         default:      w_pass = (w_pop == LP_K);
      endcase
   end

   assign w_viol = in_valid & ~w_pass;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (clr)
         w_state_nxt = ST_IDLE;
      else if (w_viol)
         w_state_nxt = ST_FAULT;
      else if (in_valid && r_state == ST_IDLE)
         w_state_nxt = ST_RUN;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y_valid  <= 1'b0;
         r_y        <= 1'b0;
         r_pop      <= '0;
         r_viol_cnt <= '0;
      end else begin
         r_y_valid <= in_valid;
         if (in_valid) begin
            r_y   <= w_pass;
            r_pop <= w_pop;
         end
         if (clr)
            r_viol_cnt <= '0;
         else if (w_viol && r_viol_cnt != CNT_MAX)
            r_viol_cnt <= r_viol_cnt + 1'b1;
      end
   end

   assign y_valid  = r_y_valid;
   assign y        = r_y;
   assign pop      = r_pop;
   assign fault    = (r_state == ST_FAULT);
   assign viol_cnt = r_viol_cnt;

`ifdef CHOICE_CAPTURE_EN
   logic [N-1:0] r_cap_vec;
   logic         r_cap_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cap_vec   <= '0;
         r_cap_valid <= 1'b0;
      end else if (clr) begin
         r_cap_vec   <= '0;
         r_cap_valid <= 1'b0;
      end else if (w_viol && !r_cap_valid) begin
         r_cap_vec   <= x;
         r_cap_valid <= 1'b1;
      end
   end

   assign cap_vec   = r_cap_vec;
   assign cap_valid = r_cap_valid;
`endif

endmodule

// File: tb/tb_choice_k_of_n_monitor.sv
// Directed bench for choice_k_of_n_monitor (N=5,K=1) plus two N=4 boundary
// instances (K=0 and K=N) sharing the clock and reset.
module tb_choice_k_of_n_monitor;
   import choice_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [4:0] x = '0;
   logic [1:0] mode = 2'b00;
   logic       clr = 1'b0;
   logic       y_valid, y, fault;
   logic [2:0] pop;
   logic [7:0] viol_cnt;

   logic       in_valid4 = 1'b0;
   logic [3:0] x4 = '0;
   logic [1:0] mode4 = 2'b00;
   logic       yv_k0, y_k0, f_k0, yv_kn, y_kn, f_kn;
   logic [2:0] pop_k0, pop_kn;
   logic [1:0] cnt_k0, cnt_kn;

`ifdef CHOICE_CAPTURE_EN
   logic [4:0] cap_vec;
   logic       cap_valid;
   logic [3:0] cv_k0, cv_kn;
   logic       cvl_k0, cvl_kn;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   choice_k_of_n_monitor #(.N(5), .K(1), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .mode(mode), .clr(clr),
      .y_valid(y_valid), .y(y), .pop(pop), .fault(fault), .viol_cnt(viol_cnt)
`ifdef CHOICE_CAPTURE_EN
      , .cap_vec(cap_vec), .cap_valid(cap_valid)
`endif
   );

   choice_k_of_n_monitor #(.N(4), .K(0), .CNT_W(2)) u_k0 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .x(x4), .mode(mode4), .clr(clr),
      .y_valid(yv_k0), .y(y_k0), .pop(pop_k0), .fault(f_k0), .viol_cnt(cnt_k0)
`ifdef CHOICE_CAPTURE_EN
      , .cap_vec(cv_k0), .cap_valid(cvl_k0)
`endif
   );

   choice_k_of_n_monitor #(.N(4), .K(4), .CNT_W(2)) u_kn (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .x(x4), .mode(mode4), .clr(clr),
      .y_valid(yv_kn), .y(y_kn), .pop(pop_kn), .fault(f_kn), .viol_cnt(cnt_kn)
`ifdef CHOICE_CAPTURE_EN
      , .cap_vec(cv_kn), .cap_valid(cvl_kn)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic beat(input logic [4:0] bx, input logic [1:0] bm);
      in_valid = 1'b1;
      x        = bx;
      mode     = bm;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Boundary vectors: x, mode, expected y for K=0, expected y for K=N.
   typedef struct {
      logic [3:0] bx;
      logic [1:0] bm;
      logic       e_k0;
      logic       e_kn;
   } bvec_t;

   bvec_t bvec [7];

   initial begin
      bvec[0] = '{4'b0000, 2'b00, 1'b1, 1'b0};
      bvec[1] = '{4'b1111, 2'b10, 1'b1, 1'b1};
      bvec[2] = '{4'b0111, 2'b10, 1'b1, 1'b0};
      bvec[3] = '{4'b0001, 2'b00, 1'b0, 1'b0};
      bvec[4] = '{4'b0010, 2'b01, 1'b0, 1'b1};
      bvec[5] = '{4'b1111, 2'b00, 1'b0, 1'b1};
      bvec[6] = '{4'b1000, 2'b00, 1'b0, 1'b0};

      #12;
      chk("rst_y_valid", 32'(y_valid), 0);
      chk("rst_y", 32'(y), 0);
      chk("rst_pop", 32'(pop), 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_cnt", 32'(viol_cnt), 0);
      chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
      @(posedge clk);
      #1 rst = 1'b0;

      // 1: one-hot pass
      beat(5'b00100, 2'b00);
      chk("t1_y_valid", 32'(y_valid), 1);
      chk("t1_y", 32'(y), 1);
      chk("t1_pop", 32'(pop), 1);
      chk("t1_fault", 32'(fault), 0);
      chk("t1_state", 32'(dut.r_state), 32'(ST_RUN));
      @(posedge clk);
      #1;
      chk("hold_y_valid", 32'(y_valid), 0);
      chk("hold_y", 32'(y), 1);
      chk("hold_pop", 32'(pop), 1);

      // 2: two bits set in exact mode
      beat(5'b10010, 2'b00);
      chk("t2_y", 32'(y), 0);
      chk("t2_pop", 32'(pop), 2);
      chk("t2_fault", 32'(fault), 1);
      chk("t2_cnt", 32'(viol_cnt), 1);
`ifdef CHOICE_CAPTURE_EN
      chk("t2_cap_vec", 32'(cap_vec), 32'h12);
      chk("t2_cap_valid", 32'(cap_valid), 1);
`endif

      // 3: mode coverage
      beat(5'b00000, 2'b01);
      chk("t3_atmost0_y", 32'(y), 1);
      chk("t3_atmost0_cnt", 32'(viol_cnt), 1);
      beat(5'b00000, 2'b10);
      chk("t3_atleast0_y", 32'(y), 0);
      chk("t3_atleast0_cnt", 32'(viol_cnt), 2);
      beat(5'b11111, 2'b10);
      chk("t3_atleast5_y", 32'(y), 1);
      chk("t3_atleast5_pop", 32'(pop), 5);
      beat(5'b00100, 2'b11);
      chk("t3_rsv_pass_y", 32'(y), 1);
      beat(5'b00110, 2'b11);
      chk("t3_rsv_fail_y", 32'(y), 0);
      chk("t3_rsv_fail_cnt", 32'(viol_cnt), 3);
      beat(5'b01100, 2'b01);
      chk("t3_atmost2_y", 32'(y), 0);
      chk("t3_atmost2_cnt", 32'(viol_cnt), 4);
      chk("t3_fault", 32'(fault), 1);
`ifdef CHOICE_CAPTURE_EN
      chk("t3_cap_kept", 32'(cap_vec), 32'h12);
`endif

      // 4: saturation, count starts at 4
      for (int i = 1; i <= 300; i++) begin
         beat(5'b00000, 2'b00);
         if (i == 250) chk("t4_cnt_254", 32'(viol_cnt), 254);
         if (i == 251) chk("t4_cnt_255", 32'(viol_cnt), 255);
      end
      chk("t4_cnt_sat", 32'(viol_cnt), 255);
      chk("t4_fault", 32'(fault), 1);

      // 5: clr together with a violating beat
      clr = 1'b1;
      beat(5'b00011, 2'b00);
      clr = 1'b0;
      chk("t5_y_valid", 32'(y_valid), 1);
      chk("t5_y", 32'(y), 0);
      chk("t5_pop", 32'(pop), 2);
      chk("t5_fault", 32'(fault), 0);
      chk("t5_cnt", 32'(viol_cnt), 0);
      chk("t5_state", 32'(dut.r_state), 32'(ST_IDLE));
`ifdef CHOICE_CAPTURE_EN
      chk("t5_cap_valid", 32'(cap_valid), 0);
      chk("t5_cap_vec", 32'(cap_vec), 0);
`endif
      beat(5'b01000, 2'b00);
      chk("t5_run_state", 32'(dut.r_state), 32'(ST_RUN));
      chk("t5_run_fault", 32'(fault), 0);

      // boundary K=0 and K=N
      for (int i = 0; i < 7; i++) begin
         in_valid4 = 1'b1;
         x4        = bvec[i].bx;
         mode4     = bvec[i].bm;
         @(posedge clk);
         #1;
         in_valid4 = 1'b0;
         chk($sformatf("k0_y_%0d", i), 32'(y_k0), 32'(bvec[i].e_k0));
         chk($sformatf("kn_y_%0d", i), 32'(y_kn), 32'(bvec[i].e_kn));
      end
      chk("k0_cnt_sat", 32'(cnt_k0), 3);
      chk("kn_cnt_sat", 32'(cnt_kn), 3);
      chk("kn_pop_last", 32'(pop_kn), 1);

      // 6: async reset mid-stream
      beat(5'b00011, 2'b00);
      chk("t6_pre_fault", 32'(fault), 1);
      chk("t6_pre_cnt", 32'(viol_cnt), 1);
      in_valid = 1'b1;
      x        = 5'b00001;
      mode     = 2'b00;
      @(posedge clk);
      #1;
      chk("t6_pre_y_valid", 32'(y_valid), 1);
      #3 rst = 1'b1;
      #1;
      chk("t6_async_y_valid", 32'(y_valid), 0);
      chk("t6_async_y", 32'(y), 0);
      chk("t6_async_pop", 32'(pop), 0);
      chk("t6_async_fault", 32'(fault), 0);
      chk("t6_async_cnt", 32'(viol_cnt), 0);
      @(posedge clk);
      #1;
      chk("t6_next_y_valid", 32'(y_valid), 0);
      rst      = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_after_y_valid", 32'(y_valid), 0);
      beat(5'b00100, 2'b00);
      chk("t6_recover_y", 32'(y), 1);
      chk("t6_recover_state", 32'(dut.r_state), 32'(ST_RUN));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
